// File: rtl/fetch_req_tracker_if.sv
// Instruction-port and IF-side bundle for the multi-outstanding fetch tracker.
// master = tracker side, slave = memory / IF side.
interface fetch_req_tracker_if;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_adel;

    modport master (
        output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_addr,
        input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
        output out_valid, out_pc, out_inst, out_adel,
        input  out_ready
    );

    modport slave (
        input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_addr,
        output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
        input  out_valid, out_pc, out_inst, out_adel,
        output out_ready
    );
endinterface

// File: rtl/fetch_req_tracker.sv
// In-order fetch tracker: up to DEPTH requests queued or in flight,
// redirect flush with a discard counter for stale responses.
module fetch_req_tracker #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       redirect,
    input  logic [31:0]                redirect_pc,
    fetch_req_tracker_if.master        bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adel;
        logic        done;
    } entry_t;

    entry_t          ent [DEPTH];
    logic [31:0]     pc;
    logic [PW-1:0]   head, resp, tail;
    logic [CW-1:0]   count, pending, discard_cnt;
    logic            halted;

    logic [CW:0]     inflight;
    logic            room, req, adel_alloc, issue, take, valid, pop, alloc;
    logic [31:0]     addr;

    assign inflight   = {1'b0, pending} + {1'b0, discard_cnt};
    assign room       = count < FULL;
    assign req        = !reset && !redirect && !halted && pc[1:0] == 2'b00
                        && room && inflight < {1'b0, FULL};
    assign adel_alloc = !reset && !redirect && !halted && pc[1:0] != 2'b00
                        && room;
    assign issue      = req && bus.inst_sram_addr_ok;
    assign alloc      = issue || adel_alloc;
    assign take       = bus.inst_sram_data_ok && discard_cnt == '0;
    assign valid      = count != '0 && ent[head].done;
    assign pop        = valid && bus.out_ready && !redirect;

    // kseg0/kseg1 map straight onto the low 512 MB; everything else passes through
    assign addr = (pc[31:30] == 2'b10) ? {3'b000, pc[28:0]} : pc;

    assign bus.inst_sram_req  = req;
    assign bus.inst_sram_wr   = 1'b0;
    assign bus.inst_sram_size = 2'd2;
    assign bus.inst_sram_addr = reset ? 32'd0 : addr;
    assign bus.out_valid      = valid;
    assign bus.out_pc         = ent[head].pc;
    assign bus.out_inst       = ent[head].inst;
    assign bus.out_adel       = ent[head].adel;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            head        <= '0;
            resp        <= '0;
            tail        <= '0;
            count       <= '0;
            pending     <= '0;
            discard_cnt <= '0;
            halted      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
        end else if (redirect) begin
            // everything still in flight becomes a stale response to drop
            pc          <= redirect_pc;
            head        <= tail;
            resp        <= tail;
            count       <= '0;
            pending     <= '0;
            halted      <= 1'b0;
            discard_cnt <= discard_cnt + pending
                           - {{PW{1'b0}}, bus.inst_sram_data_ok};
        end else begin
            if (issue) begin
                ent[tail] <= '{pc: pc, inst: 32'd0, adel: 1'b0, done: 1'b0};
                tail      <= tail + 1'b1;
                pc        <= pc + 32'd4;
            end else if (adel_alloc) begin
                ent[tail] <= '{pc: pc, inst: 32'd0, adel: 1'b1, done: 1'b1};
                tail      <= tail + 1'b1;
                halted    <= 1'b1;
            end
            if (bus.inst_sram_data_ok) begin
                if (discard_cnt != '0) begin
                    discard_cnt <= discard_cnt - 1'b1;
                end else begin
                    ent[resp].inst <= bus.inst_sram_rdata;
                    ent[resp].done <= 1'b1;
                    resp           <= resp + 1'b1;
                end
            end
            if (pop) head <= head + 1'b1;
            count   <= count + {{PW{1'b0}}, alloc} - {{PW{1'b0}}, pop};
            pending <= pending + {{PW{1'b0}}, issue} - {{PW{1'b0}}, take};
        end
    end

    a_capacity: assert property (@(posedge clk) disable iff (reset)
        inflight <= {1'b0, FULL} && count <= FULL);
endmodule

// File: tb/tb_fetch_req_tracker.sv
// Directed vector bench for fetch_req_tracker (DEPTH=4, RESET_PC=bfc00000).
// Each vector: inputs driven at negedge, outputs checked 1 ns later.
module tb_fetch_req_tracker;
    logic        clk;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_pc;

    fetch_req_tracker_if bus ();

    fetch_req_tracker #(
        .DEPTH    (4),
        .RESET_PC (32'hbfc00000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .bus         (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic [31:0] rpc;
        logic        ao;
        logic        dok;
        logic [31:0] rdata;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_v;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic        e_adel;
    } vec_t;

    vec_t vq[$];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t mk(
        input int rd, input logic [31:0] rpc, input int ao, input int dok,
        input logic [31:0] rdata, input int rdy, input int e_req,
        input logic [31:0] e_addr, input int e_v, input logic [31:0] e_pc,
        input logic [31:0] e_inst, input int e_adel);
        vec_t v;
        v.rd = (rd != 0);   v.rpc = rpc;     v.ao = (ao != 0);
        v.dok = (dok != 0); v.rdata = rdata; v.rdy = (rdy != 0);
        v.e_req = (e_req != 0); v.e_addr = e_addr; v.e_v = (e_v != 0);
        v.e_pc = e_pc; v.e_inst = e_inst; v.e_adel = (e_adel != 0);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive_idle();
        redirect              = 1'b0;
        redirect_pc           = 32'd0;
        bus.inst_sram_addr_ok = 1'b0;
        bus.inst_sram_data_ok = 1'b0;
        bus.inst_sram_rdata   = 32'd0;
        bus.out_ready         = 1'b0;
    endtask

    initial begin
        // streaming from reset
        vq.push_back(mk(0,0, 1,0,0,          1, 1,32'h1fc00000, 0,0,0,0));
        vq.push_back(mk(0,0, 1,1,32'h11110000,1, 1,32'h1fc00004, 0,0,0,0));
        vq.push_back(mk(0,0, 1,1,32'h11110001,1, 1,32'h1fc00008, 1,32'hbfc00000,32'h11110000,0));
        vq.push_back(mk(0,0, 1,1,32'h11110002,1, 1,32'h1fc0000c, 1,32'hbfc00004,32'h11110001,0));
        vq.push_back(mk(0,0, 1,1,32'h11110003,1, 1,32'h1fc00010, 1,32'hbfc00008,32'h11110002,0));
        vq.push_back(mk(0,0, 0,1,32'h11110004,1, 1,32'h1fc00014, 1,32'hbfc0000c,32'h11110003,0));
        vq.push_back(mk(0,0, 0,0,0,          1, 1,32'h1fc00014, 1,32'hbfc00010,32'h11110004,0));
        vq.push_back(mk(0,0, 0,0,0,          0, 1,32'h1fc00014, 0,0,0,0));
        // backpressure: four requests then stall, one pop frees one slot
        vq.push_back(mk(0,0, 1,0,0,          0, 1,32'h1fc00014, 0,0,0,0));
        vq.push_back(mk(0,0, 1,1,32'h22220000,0, 1,32'h1fc00018, 0,0,0,0));
        vq.push_back(mk(0,0, 1,1,32'h22220001,0, 1,32'h1fc0001c, 1,32'hbfc00014,32'h22220000,0));
        vq.push_back(mk(0,0, 1,1,32'h22220002,0, 1,32'h1fc00020, 1,32'hbfc00014,32'h22220000,0));
        vq.push_back(mk(0,0, 1,1,32'h22220003,0, 0,0,            1,32'hbfc00014,32'h22220000,0));
        vq.push_back(mk(0,0, 1,0,0,          0, 0,0,            1,32'hbfc00014,32'h22220000,0));
        vq.push_back(mk(0,0, 1,0,0,          1, 0,0,            1,32'hbfc00014,32'h22220000,0));
        vq.push_back(mk(0,0, 1,0,0,          0, 1,32'h1fc00024, 1,32'hbfc00018,32'h22220001,0));
        vq.push_back(mk(0,0, 1,1,32'h22220004,0, 0,0,            1,32'hbfc00018,32'h22220001,0));
        vq.push_back(mk(0,0, 1,0,0,          0, 0,0,            1,32'hbfc00018,32'h22220001,0));
        // redirect with three in flight
        vq.push_back(mk(1,32'h80000100, 1,0,0,1, 0,0, 1,32'hbfc00018,32'h22220001,0));
        vq.push_back(mk(0,0, 1,0,0,          1, 1,32'h00000100, 0,0,0,0));
        vq.push_back(mk(0,0, 1,0,0,          1, 1,32'h00000104, 0,0,0,0));
        vq.push_back(mk(0,0, 1,0,0,          1, 1,32'h00000108, 0,0,0,0));
        vq.push_back(mk(1,32'h80001000, 1,0,0,1, 0,0, 0,0,0,0));
        vq.push_back(mk(0,0, 1,1,32'hdead0000,1, 1,32'h00001000, 0,0,0,0));
        vq.push_back(mk(0,0, 1,1,32'hdead0001,1, 1,32'h00001004, 0,0,0,0));
        vq.push_back(mk(0,0, 1,1,32'hdead0002,1, 1,32'h00001008, 0,0,0,0));
        vq.push_back(mk(0,0, 0,1,32'h33330000,1, 1,32'h0000100c, 0,0,0,0));
        vq.push_back(mk(0,0, 0,1,32'h33330001,1, 1,32'h0000100c, 1,32'h80001000,32'h33330000,0));
        vq.push_back(mk(0,0, 0,1,32'h33330002,1, 1,32'h0000100c, 1,32'h80001004,32'h33330001,0));
        vq.push_back(mk(0,0, 0,0,0,          1, 1,32'h0000100c, 1,32'h80001008,32'h33330002,0));
        vq.push_back(mk(0,0, 0,0,0,          1, 1,32'h0000100c, 0,0,0,0));
        // redirect with a same-cycle response while two in flight
        vq.push_back(mk(0,0, 1,0,0,          1, 1,32'h0000100c, 0,0,0,0));
        vq.push_back(mk(0,0, 1,0,0,          1, 1,32'h00001010, 0,0,0,0));
        vq.push_back(mk(1,32'h80003000, 0,1,32'hbeef0000,1, 0,0, 0,0,0,0));
        vq.push_back(mk(0,0, 0,1,32'hbeef0001,1, 1,32'h00003000, 0,0,0,0));
        vq.push_back(mk(0,0, 1,0,0,          1, 1,32'h00003000, 0,0,0,0));
        vq.push_back(mk(0,0, 0,1,32'h44440000,1, 1,32'h00003004, 0,0,0,0));
        vq.push_back(mk(0,0, 0,0,0,          1, 1,32'h00003004, 1,32'h80003000,32'h44440000,0));
        vq.push_back(mk(0,0, 0,0,0,          0, 1,32'h00003004, 0,0,0,0));
        // misaligned redirect halts until the next redirect
        vq.push_back(mk(1,32'h80000002, 0,0,0,0, 0,0, 0,0,0,0));
        vq.push_back(mk(0,0, 1,0,0,          0, 0,0,            0,0,0,0));
        vq.push_back(mk(0,0, 1,0,0,          0, 0,0,            1,32'h80000002,0,1));
        vq.push_back(mk(0,0, 1,0,0,          1, 0,0,            1,32'h80000002,0,1));
        vq.push_back(mk(0,0, 1,0,0,          1, 0,0,            0,0,0,0));
        vq.push_back(mk(1,32'h80000010, 1,0,0,1, 0,0, 0,0,0,0));
        vq.push_back(mk(0,0, 1,0,0,          1, 1,32'h00000010, 0,0,0,0));
        vq.push_back(mk(0,0, 0,1,32'h55550000,1, 1,32'h00000014, 0,0,0,0));
        vq.push_back(mk(0,0, 0,0,0,          0, 1,32'h00000014, 1,32'h80000010,32'h55550000,0));
        // leave two entries queued for the mid-stream reset
        vq.push_back(mk(0,0, 1,0,0,          0, 1,32'h00000014, 1,32'h80000010,32'h55550000,0));
        vq.push_back(mk(0,0, 0,1,32'h66660000,0, 1,32'h00000018, 1,32'h80000010,32'h55550000,0));

        reset = 1'b1;
        drive_idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst req",   {31'd0, bus.inst_sram_req}, 32'd0);
        chk("rst addr",  bus.inst_sram_addr, 32'd0);
        chk("rst valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst pc",    bus.out_pc, 32'd0);
        chk("rst wr",    {31'd0, bus.inst_sram_wr}, 32'd0);
        chk("rst size",  {30'd0, bus.inst_sram_size}, 32'd2);
        reset = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            redirect              = vq[i].rd;
            redirect_pc           = vq[i].rpc;
            bus.inst_sram_addr_ok = vq[i].ao;
            bus.inst_sram_data_ok = vq[i].dok;
            bus.inst_sram_rdata   = vq[i].rdata;
            bus.out_ready         = vq[i].rdy;
            #1;
            chk($sformatf("v%0d req", i), {31'd0, bus.inst_sram_req},
                {31'd0, vq[i].e_req});
            if (vq[i].e_req)
                chk($sformatf("v%0d addr", i), bus.inst_sram_addr, vq[i].e_addr);
            chk($sformatf("v%0d valid", i), {31'd0, bus.out_valid},
                {31'd0, vq[i].e_v});
            if (vq[i].e_v) begin
                chk($sformatf("v%0d pc", i), bus.out_pc, vq[i].e_pc);
                chk($sformatf("v%0d inst", i), bus.out_inst, vq[i].e_inst);
                chk($sformatf("v%0d adel", i), {31'd0, bus.out_adel},
                    {31'd0, vq[i].e_adel});
            end
        end

        // mid-stream reset with two completed entries queued
        @(negedge clk);
        drive_idle();
        #1;
        chk("pre-rst valid", {31'd0, bus.out_valid}, 32'd1);
        reset = 1'b1;
        #1;
        chk("in-rst req", {31'd0, bus.inst_sram_req}, 32'd0);
        @(negedge clk);
        #1;
        chk("in-rst valid", {31'd0, bus.out_valid}, 32'd0);
        chk("in-rst addr",  bus.inst_sram_addr, 32'd0);
        reset = 1'b0;
        #1;
        chk("post-rst valid", {31'd0, bus.out_valid}, 32'd0);
        chk("post-rst req",   {31'd0, bus.inst_sram_req}, 32'd1);
        chk("post-rst addr",  bus.inst_sram_addr, 32'h1fc00000);
        bus.inst_sram_addr_ok = 1'b1;
        bus.out_ready         = 1'b1;
        @(negedge clk);
        bus.inst_sram_data_ok = 1'b1;
        bus.inst_sram_rdata   = 32'h77770000;
        #1;
        chk("post-rst addr2", bus.inst_sram_addr, 32'h1fc00004);
        chk("post-rst valid2", {31'd0, bus.out_valid}, 32'd0);
        @(negedge clk);
        drive_idle();
        #1;
        chk("post-rst head valid", {31'd0, bus.out_valid}, 32'd1);
        chk("post-rst head pc",   bus.out_pc, 32'hbfc00000);
        chk("post-rst head inst", bus.out_inst, 32'h77770000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
